// File: rtl/noc_traffic_injector_if.sv
// noc_traffic_injector_if: req/grant flit link from injector to local router port.
// master drives request and flit; slave returns grant and FIFO-full status.
interface noc_traffic_injector_if #(
   parameter int dataWidth = 32
);
   logic                 ReqDnStr;
   logic [dataWidth-1:0] PacketOut;
   logic                 GntDnStr;
   logic                 DnStrFull;

   modport master (
      output ReqDnStr,
      output PacketOut,
      input  GntDnStr,
      input  DnStrFull
   );

   modport slave (
      input  ReqDnStr,
      input  PacketOut,
      output GntDnStr,
      output DnStrFull
   );
endinterface

// File: rtl/noc_traffic_injector.sv
// noc_traffic_injector: LFSR-driven single-flit traffic source for a mesh NoC.
// Define INJECTOR_STATS_EN to add SentCount/StallCount outputs.
module noc_traffic_injector #(
   parameter int          dataWidth   = 32,
   parameter int          dim         = 4,
   parameter int          MESH_X      = 5,
   parameter int          MESH_Y      = 5,
   parameter int          SRC_X       = 0,
   parameter int          SRC_Y       = 0,
   parameter logic [5:0]  ModuleID    = 6'd0,
   parameter int          MODE        = 0,
   parameter int          DST_X       = 0,
   parameter int          DST_Y       = 0,
   parameter int          GAP_BITS    = 4,
   parameter int          MAX_PACKETS = 1023,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic clk,
   input  logic reset,
   input  logic InjEn,
   noc_traffic_injector_if.master dn,
`ifdef INJECTOR_STATS_EN
   output logic [31:0] SentCount,
   output logic [31:0] StallCount,
`endif
   output logic Done
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] PKT_PREP   = 3'd1;
   localparam logic [2:0] SEND_REQ   = 3'd2;
   localparam logic [2:0] WAIT_GRANT = 3'd3;
   localparam logic [2:0] DONE       = 3'd4;

   localparam int NODES = MESH_X * MESH_Y;
   localparam int NDIV  = (NODES > 1) ? NODES - 1 : 1;
   localparam int MW    = dim - 1;
   localparam bit SINGLE = (MODE == 0) && (NODES == 1);

   localparam logic [15:0] NDIV16 = 16'(NDIV);
   localparam logic [15:0] MX16   = 16'(MESH_X);
   localparam logic [15:0] SX16   = 16'(SRC_X);
   localparam logic [15:0] SY16   = 16'(SRC_Y);
   localparam logic [15:0] DX16   = 16'(DST_X);
   localparam logic [15:0] DY16   = 16'(DST_Y);
   localparam logic [15:0] SELF16 = 16'(SRC_Y * MESH_X + SRC_X);
   localparam logic [9:0]  MAX_ID = 10'(MAX_PACKETS);

   logic [2:0]           state;
   logic [15:0]          lfsr;
   logic [15:0]          lfsr_nxt;
   logic [GAP_BITS-1:0]  delay;
   logic [GAP_BITS-1:0]  count;
   logic [9:0]           pkt_id;
   logic [dim-1:0]       x_fld;
   logic [dim-1:0]       y_fld;
   logic                 req;
   logic [dataWidth-1:0] flit;
   logic [dataWidth-1:0] flit_nxt;

   logic [15:0]    idx;
   logic [15:0]    tx;
   logic [15:0]    ty;
   logic           ex;
   logic           ny;
   logic [MW-1:0]  mx;
   logic [MW-1:0]  my;
   logic [dim-1:0] x_nxt;
   logic [dim-1:0] y_nxt;

   assign lfsr_nxt = {1'b0, lfsr[15:1]}
                   ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   // Uniform mode skips our own node by shifting indices past it.
   always_comb begin
      idx = lfsr % NDIV16;
      if (idx >= SELF16)
         idx = idx + 16'd1;
      tx = idx % MX16;
      ty = idx / MX16;
      unique case (1'b1)
         (MODE == 1): begin
            tx = SY16;
            ty = SX16;
         end
         (MODE == 2): begin
            tx = DX16;
            ty = DY16;
         end
         default: ;
      endcase
      ex = tx > SX16;
      mx = MW'(ex ? tx - SX16 : SX16 - tx);
      ny = ty < SY16;
      my = MW'(ny ? SY16 - ty : ty - SY16);
      x_nxt = {ex, mx};
      y_nxt = {ny, my};
   end

   always_comb begin
      flit_nxt = '0;
      flit_nxt[4*dim+15:0] = {x_fld, y_fld,
                              {(2*dim){1'b0}},
                              pkt_id, ModuleID};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         lfsr   <= LFSR_SEED;
         delay  <= '0;
         count  <= '0;
         pkt_id <= '0;
         x_fld  <= '0;
         y_fld  <= '0;
         req    <= 1'b0;
         flit   <= '0;
      end else begin
         lfsr <= lfsr_nxt;
         case (state)
            IDLE: begin
               if (SINGLE) begin
                  state <= DONE;
               end else if (InjEn) begin
                  delay <= lfsr[GAP_BITS-1:0];
                  state <= PKT_PREP;
               end
            end
            PKT_PREP: begin
               x_fld  <= x_nxt;
               y_fld  <= y_nxt;
               pkt_id <= pkt_id + 10'd1;
               state  <= SEND_REQ;
            end
            SEND_REQ: begin
               if (count != delay) begin
                  count <= count + 1'b1;
               end else if (!dn.DnStrFull) begin
                  req   <= 1'b1;
                  flit  <= flit_nxt;
                  count <= '0;
                  state <= WAIT_GRANT;
               end
            end
            WAIT_GRANT: begin
               if (dn.GntDnStr) begin
                  req   <= 1'b0;
                  state <= (pkt_id == MAX_ID) ? DONE : IDLE;
               end
            end
            DONE: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   assign dn.ReqDnStr  = req;
   assign dn.PacketOut = flit;
   assign Done         = (state == DONE);

`ifdef INJECTOR_STATS_EN
   logic sent_ev;
   logic stall_ev;

   assign sent_ev  = (state == WAIT_GRANT) && dn.GntDnStr;
   assign stall_ev = ((state == SEND_REQ) && (count == delay)
                      && dn.DnStrFull)
                   || ((state == WAIT_GRANT) && !dn.GntDnStr);

   always_ff @(posedge clk) begin
      if (reset) begin
         SentCount  <= '0;
         StallCount <= '0;
      end else begin
         if (sent_ev && (SentCount != '1))
            SentCount <= SentCount + 32'd1;
         if (stall_ev && (StallCount != '1))
            StallCount <= StallCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_noc_traffic_injector.sv
// tb_noc_traffic_injector: directed scoreboard bench over four injector configurations.
// Expected flits come from a parallel LFSR model and the destination rules.
module tb_noc_traffic_injector;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] inj;
   logic [3:0] gnt;
   logic [3:0] full;
   logic [3:0] req_v;
   logic [3:0] done_v;
   logic [31:0] pkt_v [4];
   logic [15:0] m_lfsr;
   logic [31:0] sb [$];
   int n_pass = 0;
   int n_total = 0;
   int hit [25];
   logic [31:0] got;
   logic [31:0] first_flit;

`ifdef INJECTOR_STATS_EN
   logic [31:0] sc0, st0, sc1, st1, sc2, st2, sc3, st3;
`endif

   always #5 clk = ~clk;

   noc_traffic_injector_if #(.dataWidth(32)) b0 ();
   noc_traffic_injector_if #(.dataWidth(32)) b1 ();
   noc_traffic_injector_if #(.dataWidth(32)) b2 ();
   noc_traffic_injector_if #(.dataWidth(32)) b3 ();

   assign b0.GntDnStr = gnt[0];
   assign b1.GntDnStr = gnt[1];
   assign b2.GntDnStr = gnt[2];
   assign b3.GntDnStr = gnt[3];
   assign b0.DnStrFull = full[0];
   assign b1.DnStrFull = full[1];
   assign b2.DnStrFull = full[2];
   assign b3.DnStrFull = full[3];
   assign req_v = {b3.ReqDnStr, b2.ReqDnStr,
                   b1.ReqDnStr, b0.ReqDnStr};
   assign pkt_v[0] = b0.PacketOut;
   assign pkt_v[1] = b1.PacketOut;
   assign pkt_v[2] = b2.PacketOut;
   assign pkt_v[3] = b3.PacketOut;

   noc_traffic_injector #(
      .MODE(0), .SRC_X(2), .SRC_Y(1),
      .ModuleID(6'd5), .MAX_PACKETS(1023)
   ) u0 (
      .clk(clk), .reset(rst), .InjEn(inj[0]), .dn(b0),
`ifdef INJECTOR_STATS_EN
      .SentCount(sc0), .StallCount(st0),
`endif
      .Done(done_v[0])
   );

   noc_traffic_injector #(
      .MODE(1), .SRC_X(1), .SRC_Y(3),
      .ModuleID(6'd17), .MAX_PACKETS(3)
   ) u1 (
      .clk(clk), .reset(rst), .InjEn(inj[1]), .dn(b1),
`ifdef INJECTOR_STATS_EN
      .SentCount(sc1), .StallCount(st1),
`endif
      .Done(done_v[1])
   );

   noc_traffic_injector #(
      .MODE(2), .SRC_X(4), .SRC_Y(3), .DST_X(0), .DST_Y(0),
      .ModuleID(6'd0), .MAX_PACKETS(12)
   ) u2 (
      .clk(clk), .reset(rst), .InjEn(inj[2]), .dn(b2),
`ifdef INJECTOR_STATS_EN
      .SentCount(sc2), .StallCount(st2),
`endif
      .Done(done_v[2])
   );

   noc_traffic_injector #(
      .MODE(0), .MESH_X(1), .MESH_Y(1), .MAX_PACKETS(1)
   ) u3 (
      .clk(clk), .reset(rst), .InjEn(inj[3]), .dn(b3),
`ifdef INJECTOR_STATS_EN
      .SentCount(sc3), .StallCount(st3),
`endif
      .Done(done_v[3])
   );

   always_ff @(posedge clk) begin
      if (rst)
         m_lfsr <= 16'hACE1;
      else
         m_lfsr <= (m_lfsr >> 1)
                 ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   function automatic logic [5:0] mid_of(input int u);
      return (u == 0) ? 6'd5 : (u == 1) ? 6'd17 : 6'd0;
   endfunction

   function automatic logic [7:0] exp_xy(input int u,
                                         input logic [15:0] l);
      int sx, sy, tx, ty, idx, mx, my;
      logic ex, ny;
      sx = (u == 0) ? 2 : (u == 1) ? 1 : 4;
      sy = (u == 0) ? 1 : 3;
      if (u == 1) begin
         tx = sy;
         ty = sx;
      end else if (u == 2) begin
         tx = 0;
         ty = 0;
      end else begin
         idx = int'(l) % 24;
         if (idx >= sy * 5 + sx)
            idx++;
         tx = idx % 5;
         ty = idx / 5;
      end
      ex = tx > sx;
      mx = ex ? tx - sx : sx - tx;
      ny = ty < sy;
      my = ny ? sy - ty : ty - sy;
      return {ex, 3'(mx), ny, 3'(my)};
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h",
                  tag, obs, exp);
   endtask

   // Entry: #1 after an edge with DUT u idle; its next edge samples InjEn.
   task automatic run_pkt(input int u, input int id,
                          input int glat, input int fcyc,
                          input bit last,
                          output logic [31:0] o);
      logic [3:0] d;
      logic [31:0] e;
      int n, want;
      d = m_lfsr[3:0];
      if (fcyc > 0)
         full[u] = 1'b1;
      @(posedge clk); #1;
      sb.push_back({exp_xy(u, m_lfsr), 8'h00,
                    10'(id), mid_of(u)});
      want = (fcyc + 1 > int'(d) + 2) ? fcyc + 1 : int'(d) + 2;
      n = 0;
      while (req_v[u] !== 1'b1 && n < 64) begin
         @(posedge clk); #1;
         n++;
         if (n == fcyc)
            full[u] = 1'b0;
      end
      full[u] = 1'b0;
      chk("req_latency", 32'(n), 32'(want));
      o = pkt_v[u];
      e = sb.pop_front();
      chk("flit", o, e);
      for (int k = 0; k < glat; k++) begin
         @(posedge clk); #1;
         chk("req_hold", 32'(req_v[u]), 32'd1);
         chk("flit_hold", pkt_v[u], e);
      end
      gnt[u] = 1'b1;
      @(posedge clk); #1;
      gnt[u] = 1'b0;
      chk("req_fall", 32'(req_v[u]), 32'd0);
      chk("flit_after_gnt", pkt_v[u], e);
      chk("done", 32'(done_v[u]), 32'(last));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tx, ty, self_hits, missed, n;
      logic [3:0] xf, yf;
      rst = 1'b1;
      inj = '0;
      gnt = '0;
      full = '0;
      foreach (hit[i]) hit[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 4; u++) begin
         chk("rst_req", 32'(req_v[u]), 32'd0);
         chk("rst_pkt", pkt_v[u], 32'd0);
         chk("rst_done", 32'(done_v[u]), 32'd0);
      end
      rst = 1'b0;
      inj[3] = 1'b1;

      inj[2] = 1'b1;
      run_pkt(2, 1, 1, 0, 1'b0, got);
      chk("fixed_first_flit", got, 32'h4B00_0040);
      run_pkt(2, 2, 1, 20, 1'b0, got);
      chk("fixed_id2_flit", got, 32'h4B00_0080);
      inj[2] = 1'b0;

      chk("single_node_done", 32'(done_v[3]), 32'd1);
      chk("single_node_req", 32'(req_v[3]), 32'd0);

      inj[1] = 1'b1;
      for (int id = 1; id <= 3; id++) begin
         run_pkt(1, id, 2, 0, id == 3, got);
         chk("transpose_fields", 32'(got[31:24]), 32'hAA);
      end
      repeat (5) @(posedge clk);
      #1;
      chk("done_absorb", 32'(done_v[1]), 32'd1);
      chk("done_no_req", 32'(req_v[1]), 32'd0);
      inj[1] = 1'b0;

      inj[0] = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      self_hits = 0;
      for (int id = 1; id <= 1023; id++) begin
         run_pkt(0, id, 0, 0, id == 1023, got);
         if (id == 1)
            first_flit = got;
         xf = got[31:28];
         yf = got[27:24];
         tx = xf[3] ? 2 + int'(xf[2:0]) : 2 - int'(xf[2:0]);
         ty = yf[3] ? 1 - int'(yf[2:0]) : 1 + int'(yf[2:0]);
         if (tx == 2 && ty == 1)
            self_hits++;
         else if (tx >= 0 && tx < 5 && ty >= 0 && ty < 5)
            hit[ty * 5 + tx]++;
      end
      missed = 0;
      for (int i = 0; i < 25; i++)
         if (i != 7 && hit[i] == 0)
            missed++;
      chk("uniform_self_hits", 32'(self_hits), 32'd0);
      chk("uniform_nodes_missed", 32'(missed), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("uniform_done_hold", 32'(done_v[0]), 32'd1);

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0;
      while (req_v[0] !== 1'b1 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_test_req_up", 32'(req_v[0]), 32'd1);
      gnt[0] = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      gnt[0] = 1'b0;
      rst = 1'b0;
      chk("gnt_rst_req", 32'(req_v[0]), 32'd0);
      chk("gnt_rst_pkt", pkt_v[0], 32'd0);
      chk("gnt_rst_done", 32'(done_v[0]), 32'd0);
      run_pkt(0, 1, 0, 0, 1'b0, got);
      inj[0] = 1'b0;
      chk("reseed_same_first", got, first_flit);

`ifdef INJECTOR_STATS_EN
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      inj[2] = 1'b1;
      for (int id = 1; id <= 10; id++)
         run_pkt(2, id, 4, 0, 1'b0, got);
      inj[2] = 1'b0;
      chk("sent_count", sc2, 32'd10);
      chk("stall_count", st2, 32'd40);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
